// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the execute/memory pipeline boundary
package cpu_pkg;

    localparam int BIT_WISE = 64;

    // Flag bit positions, shared by e_flags and the condition-code register
    localparam int ZF = 0;
    localparam int SF = 1;
    localparam int OF = 2;
    localparam int CF = 3;

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - jXX/cmovXX condition evaluation from the condition codes
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic w_lt;
    logic w_unused_cf;

    assign w_lt        = cc[SF] ^ cc[OF];
    // Carry is kept architecturally but no condition depends on it
    assign w_unused_cf = cc[CF];

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = w_lt | cc[ZF];
            C_L:     cnd = w_lt;
            C_E:     cnd = cc[ZF];
            C_NE:    cnd = ~cc[ZF];
            C_GE:    cnd = ~w_lt;
            C_G:     cnd = ~w_lt & ~cc[ZF];
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_mem_stage.sv
// rtl/exec_mem_stage.sv - condition codes and the E-to-M pipeline register
module exec_mem_stage #(
    parameter int BIT_WISE = cpu_pkg::BIT_WISE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                e_valid,
    input  logic [3:0]          e_icode,
    input  logic [3:0]          e_ifun,
    input  logic [BIT_WISE-1:0] e_valE,
    input  logic [3:0]          e_flags,
    input  logic [BIT_WISE-1:0] e_valA,
    input  logic [3:0]          e_dstE,
    input  logic [3:0]          e_dstM,
    input  logic                exc_pending,
    input  logic                m_stall,
    input  logic                m_bubble,
    output logic [3:0]          cc_q,
    output logic                e_cnd,
    output logic                m_valid,
    output logic [3:0]          m_icode,
    output logic                m_cnd,
    output logic [BIT_WISE-1:0] m_valE,
    output logic [BIT_WISE-1:0] m_valA,
    output logic [3:0]          m_dstE,
    output logic [3:0]          m_dstM
);

    import cpu_pkg::*;

    logic [3:0]          r_cc;
    logic                r_m_valid;
    logic [3:0]          r_m_icode;
    logic                r_m_cnd;
    logic [BIT_WISE-1:0] r_m_valE;
    logic [BIT_WISE-1:0] r_m_valA;
    logic [3:0]          r_m_dstE;
    logic [3:0]          r_m_dstM;

    logic                w_cc_we;
    logic [3:0]          w_dstE;

    // Reads the registered codes, so an OPq updating CC is seen only by later instructions
    cond_eval u_cond_eval (
        .cc   (r_cc),
        .ifun (e_ifun),
        .cnd  (e_cnd)
    );

    assign w_cc_we = e_valid && (e_icode == IOPQ) && !exc_pending && !m_stall;
    assign w_dstE  = ((e_icode == IRRMOVQ) && !e_cnd) ? RNONE : e_dstE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cc <= 4'b0001;
        end else if (w_cc_we) begin
            r_cc <= e_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (!m_stall && (m_bubble || !e_valid))) begin
            r_m_valid <= 1'b0;
            r_m_icode <= INOP;
            r_m_cnd   <= 1'b0;
            r_m_valE  <= '0;
            r_m_valA  <= '0;
            r_m_dstE  <= RNONE;
            r_m_dstM  <= RNONE;
        end else if (!m_stall) begin
            r_m_valid <= 1'b1;
            r_m_icode <= e_icode;
            r_m_cnd   <= e_cnd;
            r_m_valE  <= e_valE;
            r_m_valA  <= e_valA;
            r_m_dstE  <= w_dstE;
            r_m_dstM  <= e_dstM;
        end
    end

    assign cc_q    = r_cc;
    assign m_valid = r_m_valid;
    assign m_icode = r_m_icode;
    assign m_cnd   = r_m_cnd;
    assign m_valE  = r_m_valE;
    assign m_valA  = r_m_valA;
    assign m_dstE  = r_m_dstE;
    assign m_dstM  = r_m_dstM;

endmodule

// File: tb/tb_exec_mem_stage.sv
// tb/tb_exec_mem_stage.sv - randomized and directed checks of exec_mem_stage against a reference model
module tb_exec_mem_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         e_valid;
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic [W-1:0] e_valE;
    logic [3:0]   e_flags;
    logic [W-1:0] e_valA;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;
    logic         exc_pending;
    logic         m_stall;
    logic         m_bubble;
    logic [3:0]   cc_q;
    logic         e_cnd;
    logic         m_valid;
    logic [3:0]   m_icode;
    logic         m_cnd;
    logic [W-1:0] m_valE;
    logic [W-1:0] m_valA;
    logic [3:0]   m_dstE;
    logic [3:0]   m_dstM;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [3:0]   mdl_cc;
    logic         mdl_valid;
    logic [3:0]   mdl_icode;
    logic         mdl_cnd;
    logic [W-1:0] mdl_valE;
    logic [W-1:0] mdl_valA;
    logic [3:0]   mdl_dstE;
    logic [3:0]   mdl_dstM;

    exec_mem_stage #(.BIT_WISE(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .e_valid     (e_valid),
        .e_icode     (e_icode),
        .e_ifun      (e_ifun),
        .e_valE      (e_valE),
        .e_flags     (e_flags),
        .e_valA      (e_valA),
        .e_dstE      (e_dstE),
        .e_dstM      (e_dstM),
        .exc_pending (exc_pending),
        .m_stall     (m_stall),
        .m_bubble    (m_bubble),
        .cc_q        (cc_q),
        .e_cnd       (e_cnd),
        .m_valid     (m_valid),
        .m_icode     (m_icode),
        .m_cnd       (m_cnd),
        .m_valE      (m_valE),
        .m_valA      (m_valA),
        .m_dstE      (m_dstE),
        .m_dstM      (m_dstM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_cond(input logic [3:0] cc, input logic [3:0] ifun);
        bit zf = cc[0];
        bit sf = cc[1];
        bit of_ = cc[2];
        bit less = (sf != of_);
        case (ifun)
            4'd0: return 1'b1;
            4'd1: return less || zf;
            4'd2: return less;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !less;
            4'd6: return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_nop();
        mdl_valid = 1'b0;
        mdl_icode = 4'h1;
        mdl_cnd   = 1'b0;
        mdl_valE  = '0;
        mdl_valA  = '0;
        mdl_dstE  = 4'hF;
        mdl_dstM  = 4'hF;
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [W-1:0] ve, input logic [3:0] fl, input logic [3:0] de,
                         input logic ex, input logic st, input logic bu);
        e_valid     = v;
        e_icode     = ic;
        e_ifun      = fn;
        e_valE      = ve;
        e_flags     = fl;
        e_valA      = ~ve;
        e_dstE      = de;
        e_dstM      = de ^ 4'h5;
        exc_pending = ex;
        m_stall     = st;
        m_bubble    = bu;
    endtask

    // Inputs are stable at entry; checks e_cnd, advances one edge, then checks all state
    task automatic run_cycle();
        logic c;
        logic [3:0] nxt_cc;
        #1;
        c = model_cond(mdl_cc, e_ifun);
        check("e_cnd", e_cnd, c);
        nxt_cc = mdl_cc;
        if (!rst_n) nxt_cc = 4'b0001;
        else if (e_valid && e_icode == 4'h6 && !exc_pending && !m_stall) nxt_cc = e_flags;
        if (!rst_n) model_nop();
        else if (m_stall) ;
        else if (m_bubble || !e_valid) model_nop();
        else begin
            mdl_valid = 1'b1;
            mdl_icode = e_icode;
            mdl_cnd   = c;
            mdl_valE  = e_valE;
            mdl_valA  = e_valA;
            mdl_dstE  = (e_icode == 4'h2 && !c) ? 4'hF : e_dstE;
            mdl_dstM  = e_dstM;
        end
        mdl_cc = nxt_cc;
        @(posedge clk);
        #1;
        check("cc_q",    cc_q,    mdl_cc);
        check("m_valid", m_valid, mdl_valid);
        check("m_icode", m_icode, mdl_icode);
        check("m_cnd",   m_cnd,   mdl_cnd);
        check("m_valE",  m_valE,  mdl_valE);
        check("m_valA",  m_valA,  mdl_valA);
        check("m_dstE",  m_dstE,  mdl_dstE);
        check("m_dstM",  m_dstM,  mdl_dstM);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 4'h0, 4'h0, '0, 4'h0, 4'h0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        mdl_cc = 4'b0001;
        model_nop();

        // Reset release with nothing valid
        rst_n = 1'b1;
        run_cycle();
        check("r031_cc", cc_q, 4'b0001);
        check("r031_valid", m_valid, 1'b0);
        check("r031_icode", m_icode, 4'h1);
        check("r031_dst", {m_dstE, m_dstM}, 8'hFF);

        // Exception blocks the CC update
        drive(1, 4'h6, 4'h0, 64'h10, 4'b0000, 4'h2, 1, 0, 0);
        run_cycle();
        check("r033_cc", cc_q, 4'b0001);
        drive(1, 4'h7, 4'h3, 64'h20, 4'b0000, 4'hF, 0, 0, 0);
        #1;
        check("r033_ecnd", e_cnd, 1'b1);
        run_cycle();

        // SF set then jl sees it on the following cycle
        drive(1, 4'h6, 4'h1, 64'h30, 4'b0010, 4'h4, 0, 0, 0);
        #1;
        check("r024_old_cc", e_cnd, 1'b1);
        run_cycle();
        drive(1, 4'h7, 4'h2, 64'h40, 4'b1111, 4'hF, 0, 0, 0);
        #1;
        check("r032_ecnd", e_cnd, 1'b1);
        run_cycle();
        check("r032_mcnd", m_cnd, 1'b1);

        // cmovne rejected with ZF=1, taken with ZF=0
        drive(1, 4'h6, 4'h0, 64'h0, 4'b0001, 4'h1, 0, 0, 0);
        run_cycle();
        drive(1, 4'h2, 4'h4, 64'h50, 4'b0000, 4'h3, 0, 0, 0);
        run_cycle();
        check("r034_reject", m_dstE, 4'hF);
        drive(1, 4'h6, 4'h0, 64'h1, 4'b0000, 4'h1, 0, 0, 0);
        run_cycle();
        drive(1, 4'h2, 4'h4, 64'h60, 4'b0000, 4'h3, 0, 0, 0);
        run_cycle();
        check("r034_take", m_dstE, 4'h3);

        // Stall beats bubble; bubble alone inserts a NOP
        drive(1, 4'h5, 4'h0, 64'h1234, 4'b1010, 4'h6, 0, 0, 0);
        run_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1, 4'h6, 4'h0, 64'h9999, 4'b1110, 4'h7, 0, 1, 1);
            run_cycle();
            check("r035_hold", m_valE, 64'h1234);
        end
        drive(1, 4'h3, 4'h0, 64'h7777, 4'b0000, 4'h8, 0, 0, 1);
        run_cycle();
        check("r035_bub_valid", m_valid, 1'b0);
        check("r035_bub_icode", m_icode, 4'h1);
        check("r035_bub_valE", m_valE, 64'h0);

        // Reset during a stall discards held contents
        drive(1, 4'h5, 4'h0, 64'h55, 4'b0000, 4'h9, 0, 0, 0);
        run_cycle();
        drive(1, 4'h6, 4'h0, 64'hAA, 4'b0100, 4'h9, 0, 1, 0);
        run_cycle();
        check("r036_held", m_valE, 64'h55);
        rst_n = 1'b0;
        run_cycle();
        check("r036_valE", m_valE, 64'h0);
        check("r036_icode", m_icode, 4'h1);
        check("r036_cc", cc_q, 4'b0001);
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] ic;
            case ($urandom_range(0, 3))
                0: ic = 4'h2;
                1: ic = 4'h6;
                2: ic = 4'h7;
                default: ic = 4'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, ic,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6)),
                  {$urandom, $urandom}, 4'($urandom), 4'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0);
            rst_n = ($urandom_range(0, 39) != 0);
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exec_mem_stage.md
EXEC_MEM_STAGE -- requirements
Module: exec_mem_stage

Interface
REQ-001 SHALL have parameter BIT_WISE, default 64, giving the datapath width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port e_valid, input, 1 bit: the execute-stage instruction is valid.
REQ-005 SHALL have ports e_icode and e_ifun, inputs, 4 bits each: the instruction code and function code in execute.
REQ-006 SHALL have port e_valE, input, BIT_WISE bits: the ALU result.
REQ-007 SHALL have port e_flags, input, 4 bits: the ALU flags {CF,OF,SF,ZF}, with bit 0=ZF, 1=SF, 2=OF, 3=CF.
REQ-008 SHALL have port e_valA, input, BIT_WISE bits: the store data or pass-through operand.
REQ-009 SHALL have ports e_dstE and e_dstM, inputs, 4 bits each: the destination register IDs (4'hF = RNONE).
REQ-010 SHALL have port exc_pending, input, 1 bit: an exception is in memory or write-back.
REQ-011 SHALL have ports m_stall and m_bubble, inputs, 1 bit each: the pipeline-control requests for the M register.
REQ-012 SHALL have port cc_q, output, 4 bits: the architectural condition-code register.
REQ-013 SHALL have port e_cnd, output, 1 bit: the combinational condition result for the instruction in execute.
REQ-014 SHALL have ports m_valid (1 bit), m_icode (4), m_cnd (1), m_valE (BIT_WISE), m_valA (BIT_WISE), m_dstE (4) and m_dstM (4), outputs: the registered M-stage fields.

Function
REQ-015 e_cnd SHALL be evaluated from cc_q, never from e_flags, as follows:
- ifun 0: 1
- ifun 1 (le): (SF^OF)|ZF
- ifun 2 (l): SF^OF
- ifun 3 (e): ZF
- ifun 4 (ne): !ZF
- ifun 5 (ge): !(SF^OF)
- ifun 6 (g): !(SF^OF)&!ZF
- ifun 7..15: 0
REQ-016 cc_q SHALL load e_flags at the clock edge iff e_valid && e_icode==IOPQ && !exc_pending && !m_stall; otherwise cc_q SHALL hold.
REQ-017 Register update priority SHALL be: reset, then m_stall (hold all m_* fields), then m_bubble (insert NOP), then normal load.
REQ-018 A NOP insert SHALL set m_valid=0, m_icode=INOP (4'h1), m_cnd=0, m_valE=0, m_valA=0, m_dstE=4'hF and m_dstM=4'hF.
REQ-019 A normal load SHALL copy e_icode, e_valE, e_valA, e_dstM and e_cnd into the M register, with m_valid=e_valid.
REQ-020 A normal load SHALL set m_dstE=4'hF when e_icode==IRRMOVQ && !e_cnd (rejected cmov); otherwise m_dstE=e_dstE.
REQ-021 A normal load with e_valid=0 SHALL be identical to a NOP insert.
REQ-022 Latency SHALL be exactly 1 cycle from the E inputs to the m_* outputs, and 0 cycles from cc_q to e_cnd.
REQ-023 When m_stall and m_bubble are asserted together, the stall SHALL win and the M register SHALL hold.
REQ-024 A cc_q update and a cmov/jXX read of cc_q in the same cycle SHALL see the old cc_q; the new value SHALL be visible from the next cycle.
REQ-025 The e_flags bit layout SHALL match cc_q exactly; CF SHALL be stored but SHALL NOT be used by any ifun.

Reset
REQ-026 While rst_n==0 at a clock edge, cc_q SHALL become 4'b0001 (ZF=1).
REQ-027 While rst_n==0 at a clock edge, all m_* outputs SHALL take the NOP values of REQ-018.
REQ-028 Reset SHALL override m_stall, m_bubble and the CC-update enable; asserting reset mid-stall SHALL discard the held M contents.

Structure
REQ-029 The shared package cpu_pkg SHALL hold:
- BIT_WISE
- the flag indices ZF/SF/OF/CF
- icode constants INOP, IRRMOVQ (2), IOPQ (6), IJXX (7)
- condition ifun constants
- RNONE
REQ-030 The condition evaluation SHALL be a separate combinational sub-module cond_eval(cc, ifun -> cnd), and exec_mem_stage SHALL instantiate it once.

Verification
REQ-031 Reset release, with no valid instruction applied -> cc_q=4'b0001; m_valid=0; m_icode=1; m_dstE=m_dstM=F.
REQ-032 OPq with e_flags=4'b0010 (SF=1), then jXX ifun 2 on the next cycle -> e_cnd=1; m_cnd=1 one cycle later.
REQ-033 OPq with exc_pending=1 and e_flags=4'b0000 -> cc_q stays 4'b0001, and a following jXX ifun 3 gives e_cnd=1.
REQ-034 cmov (icode 2, ifun 4) with cc_q ZF=1 and e_dstE=3 -> m_dstE=F; with ZF=0 -> m_dstE=3.
REQ-035 Load valE=0x1234, then hold m_stall=1 and m_bubble=1 for 2 cycles -> m_valE stays 0x1234; with m_bubble alone on the next cycle -> NOP fields.
REQ-036 Assert rst_n=0 during a stall with m_valE=0x55 -> the next edge gives NOP fields and cc_q=4'b0001.
